test_sink_rr_arbiter: RTL and testbench



---
 rtl/test_sink_rr_arbiter.sv | 118 +++++++++++
 tb/tb_test_sink_rr_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/test_sink_rr_arbiter.sv
// rtl/test_sink_rr_arbiter.sv - round-robin merge of val/rdy response streams into one test sink
// Winner is tagged with its source id and held in a one-entry output buffer; adds watchdog and completion flag.
module test_sink_rr_arbiter #(
  parameter int p_nreqs     = 4,
  parameter int p_msg_nbits = 32,
  parameter int p_cnt_nbits = 16,
  parameter int p_timeout   = 10000,
  localparam int c_id_nbits = (p_nreqs > 1) ? $clog2(p_nreqs) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_nreqs-1:0]                req_val,
  output logic [p_nreqs-1:0]                req_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0]    req_msg,
  output logic                              sink_val,
  input  logic                              sink_rdy,
  output logic [c_id_nbits+p_msg_nbits-1:0] sink_msg,
  input  logic                              sink_done,
  output logic [p_nreqs*p_cnt_nbits-1:0]    req_cnt,
  output logic                              all_done,
  output logic                              timeout
);

  localparam int c_wd_nbits = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state, state_next;
  logic [c_id_nbits-1:0]   ptr, ptr_next, grant_id;
  logic [p_msg_nbits-1:0]  grant_msg;
  logic                    accept, drain, can_accept;
  logic [p_cnt_nbits-1:0]  cnt_q [p_nreqs];
  logic [c_wd_nbits-1:0]   wd_cnt, wd_inc;

  assign sink_val   = (state == FULL);
  assign drain      = sink_val && sink_rdy;
  assign can_accept = !reset && ((state == EMPTY) || drain);

  // First valid requester at or after ptr wins; lower-priority inputs cannot affect it.
  always_comb begin
    int idx;
    idx       = 0;
    accept    = 1'b0;
    grant_id  = '0;
    grant_msg = '0;
    ptr_next  = ptr;
    req_rdy   = '0;
    if (can_accept) begin
      for (int k = 0; k < p_nreqs; k++) begin
        idx = (int'(ptr) + k) % p_nreqs;
        if (!accept && req_val[idx]) begin
          accept    = 1'b1;
          grant_id  = idx[c_id_nbits-1:0];
          grant_msg = req_msg[idx*p_msg_nbits +: p_msg_nbits];
          ptr_next  = c_id_nbits'((idx + 1) % p_nreqs);
          req_rdy[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = FULL;
    end else if (drain) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      sink_msg <= '0;
      ptr      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        sink_msg <= {grant_id, grant_msg};
        ptr      <= ptr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < p_nreqs; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else if (accept && (grant_id == c_id_nbits'(i)) && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < p_nreqs; i++) begin : g_cnt_pack
    assign req_cnt[i*p_cnt_nbits +: p_cnt_nbits] = cnt_q[i];
  end

  // Once timeout latches the counter freezes, so it never wraps back past p_timeout.
  assign wd_inc = wd_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (drain || sink_done) begin
      wd_cnt <= '0;
    end else if ((p_timeout != 0) && !timeout) begin
      wd_cnt <= wd_inc;
      if (wd_inc == c_wd_nbits'(p_timeout)) begin
        timeout <= 1'b1;
      end
    end
  end

  assign all_done = sink_done && (state == EMPTY) && (req_val == '0) && !reset;

endmodule

// File: tb/tb_test_sink_rr_arbiter.sv
// tb/tb_test_sink_rr_arbiter.sv - vector table, corner sequences and randomized model check of test_sink_rr_arbiter
module tb_test_sink_rr_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_val;
  logic [3:0]   req_rdy;
  logic [127:0] req_msg;
  logic         sink_val;
  logic         sink_rdy;
  logic [33:0]  sink_msg;
  logic         sink_done;
  logic [15:0]  req_cnt;
  logic         all_done;
  logic         timeout;

  test_sink_rr_arbiter #(
    .p_nreqs(4), .p_msg_nbits(32), .p_cnt_nbits(4), .p_timeout(8)
  ) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .sink_val(sink_val), .sink_rdy(sink_rdy), .sink_msg(sink_msg), .sink_done(sink_done),
    .req_cnt(req_cnt), .all_done(all_done), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: occupancy flag + held message, integer pointer, counters, idle-cycle count.
  bit          m_known = 1'b0;
  bit          m_full;
  logic [33:0] m_msg;
  int          m_ptr;
  int          m_cnt [4];
  int          m_idle;
  bit          m_to;
  int          m_g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (reset || (m_full && !sink_rdy)) return -1;
    for (int k = 0; k < 4; k++) begin
      if (req_val[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_check();
    logic [3:0] exp_rdy;
    m_g = model_grant();
    if (!m_known) return;
    exp_rdy = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
    check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    check("sink_val", 64'(sink_val), 64'(m_full));
    check("sink_msg", 64'(sink_msg), 64'(m_msg));
    for (int i = 0; i < 4; i++) check("req_cnt", 64'(req_cnt[i*4 +: 4]), 64'(m_cnt[i]));
    check("timeout", 64'(timeout), 64'(m_to));
    check("all_done", 64'(all_done), 64'(sink_done && !m_full && (req_val == 4'b0) && !reset));
  endtask

  task automatic model_update();
    bit drained;
    logic [1:0] gid;
    if (reset) begin
      m_known = 1'b1;
      m_full  = 1'b0;
      m_msg   = '0;
      m_ptr   = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_idle  = 0;
      m_to    = 1'b0;
      return;
    end
    drained = m_full && sink_rdy;
    if (m_g >= 0) begin
      gid    = m_g[1:0];
      m_full = 1'b1;
      m_msg  = {gid, req_msg[m_g*32 +: 32]};
      m_ptr  = (m_g + 1) % 4;
      if (m_cnt[m_g] < 15) m_cnt[m_g]++;
    end else if (drained) begin
      m_full = 1'b0;
    end
    if (drained || sink_done) begin
      m_idle = 0;
    end else if (!m_to) begin
      m_idle++;
      if (m_idle == 8) m_to = 1'b1;
    end
  endtask

  // One clock: drive at the falling edge, check away from the rising edge, then advance the model.
  task automatic cycle(input logic rst, input logic [3:0] val, input logic srdy, input logic sdone,
                       input logic [127:0] msg);
    @(negedge clk);
    reset = rst; req_val = val; sink_rdy = srdy; sink_done = sdone; req_msg = msg;
    #1;
    model_check();
    model_update();
  endtask

  function automatic logic [127:0] row_msg(input int row);
    logic [127:0] m;
    for (int i = 0; i < 4; i++) m[i*32 +: 32] = {4'hA, 4'(i), 8'hAA, 16'(row)};
    return m;
  endfunction

  function automatic logic [127:0] rand_msg();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct packed {
    logic       rst;
    logic [3:0] val;
    logic       srdy;
    logic       sdone;
    logic [3:0] rdy;
    logic       sval;
    logic [1:0] id;
    logic       done;
  } vec_t;

  vec_t tbl [26];

  initial begin
    reset = 1'b1; req_val = '0; sink_rdy = 1'b0; sink_done = 1'b0; req_msg = '0;

    tbl[0]  = {1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[1]  = {1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0};
    tbl[2]  = {1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[3]  = {1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[4]  = {1'b0, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0};
    tbl[5]  = {1'b0, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b0};
    tbl[6]  = {1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3, 1'b0};
    tbl[7]  = {1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0};
    tbl[8]  = {1'b0, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 1'b0};
    tbl[9]  = {1'b0, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b0};
    tbl[10] = {1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3, 1'b0};
    tbl[11] = {1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0};
    tbl[12] = {1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[13] = {1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[14] = {1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[15] = {1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[16] = {1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[17] = {1'b0, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 1'b0};
    tbl[18] = {1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[19] = {1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[20] = {1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[21] = {1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[22] = {1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[23] = {1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[24] = {1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0};
    tbl[25] = {1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0};

    cycle(1'b1, 4'b1111, 1'b1, 1'b0, '0);
    cycle(1'b1, 4'b1111, 1'b1, 1'b0, '0);

    for (int r = 0; r < 26; r++) begin
      cycle(tbl[r].rst, tbl[r].val, tbl[r].srdy, tbl[r].sdone, row_msg(r));
      check("tbl_rdy", 64'(req_rdy), 64'(tbl[r].rdy));
      check("tbl_sink_val", 64'(sink_val), 64'(tbl[r].sval));
      if (tbl[r].sval) check("tbl_sink_id", 64'(sink_msg[33:32]), 64'(tbl[r].id));
      check("tbl_all_done", 64'(all_done), 64'(tbl[r].done));
      if (r == 2) check("first_msg", 64'(sink_msg), 64'({2'd1, 32'hA1AA0001}));
      if (r == 3) check("second_msg", 64'(sink_msg), 64'({2'd1, 32'hA1AA0002}));
      if (r == 12) check("counts_after_rr", 64'(req_cnt), 64'({4'd2, 4'd2, 4'd4, 4'd2}));
      if (r == 16) check("held_msg", 64'(sink_msg), 64'({2'd1, 32'hA1AA000B}));
      if (r == 20) check("counts_after_reset", 64'(req_cnt), 64'(16'h0000));
    end

    // Watchdog: one buffered message, sink stalled, no sink_done.
    cycle(1'b1, 4'b0000, 1'b0, 1'b0, '0);
    cycle(1'b0, 4'b0001, 1'b0, 1'b0, rand_msg());
    for (int k = 0; k < 7; k++) cycle(1'b0, 4'b0000, 1'b0, 1'b0, rand_msg());
    check("wd_before_limit", 64'(timeout), 64'(1'b0));
    cycle(1'b0, 4'b0000, 1'b0, 1'b0, rand_msg());
    check("wd_at_limit", 64'(timeout), 64'(1'b1));
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'b0000, 1'b1, 1'b0, rand_msg());
    check("wd_sticky", 64'(timeout), 64'(1'b1));
    cycle(1'b1, 4'b0000, 1'b1, 1'b0, '0);
    cycle(1'b0, 4'b0000, 1'b1, 1'b1, '0);
    check("wd_cleared", 64'(timeout), 64'(1'b0));

    // Counter saturation on a single busy requester.
    for (int k = 0; k < 20; k++) cycle(1'b0, 4'b0100, 1'b1, 1'b1, rand_msg());
    check("cnt_saturate", 64'(req_cnt[11:8]), 64'(4'hF));

    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), rand_msg());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
